trng_health_collector: RTL and testbench
========================================

Name: trng_health_collector

Overview:
Sits between the synchronized ring-oscillator raw entropy bit and the pwhash TRNG port (trng_req / trng_word / trng_valid).
- Samples the raw bit at a fixed divided rate.
- Runs continuous SP 800-90B-style health tests: the repetition count test (RCT) and the adaptive proportion test (APT).
- Packs fresh samples into TRNG_WIDTH-bit words and answers pwhash requests from a one-word buffer.
- On any health failure it latches a sticky fault and stops supplying words.

Parameters:
TRNG_WIDTH, 8, output word width in bits (>=2)
SAMPLE_DIV, 4, clk cycles per raw-bit sample strobe (>=1)
STARTUP_SAMPLES, 1024, samples tested and discarded before the first word is collected
RCT_CUTOFF, 32, consecutive identical samples that trip the RCT
APT_WINDOW, 512, APT window length in samples
APT_CUTOFF, 410, occurrences of the window's reference value that trip the APT

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
raw_bit  input  1  entropy bit, already synchronized to clk
trng_req  input  1  level request from pwhash, held high until trng_valid
trng_word  output  TRNG_WIDTH  delivered random word
trng_valid  output  1  one-cycle pulse; trng_word is valid in that cycle
health_fail  output  1  sticky health-test failure flag

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (resetn). While resetn is low, all state clears.
  - trng_word=0, trng_valid=0, health_fail=0.
  - Divider=0, counters=0, buffer empty, state STARTUP.
- Sample strobe: the divider counts 0..SAMPLE_DIV-1, and the strobe fires when it equals SAMPLE_DIV-1. The first strobe occurs SAMPLE_DIV cycles after reset release. All tests and collection act only on strobe cycles.
- RCT:
  - The first sample sets run=1.
  - A sample equal to the previous one increments run (saturating); a different sample resets run to 1.
  - When run reaches RCT_CUTOFF, the block fails.
- APT:
  - The first sample of each window is the reference; count=1.
  - Each later sample in the window that equals the reference increments count.
  - When count reaches APT_CUTOFF, the block fails.
  - After APT_WINDOW samples, the next sample starts a new window.
- Both tests run on every strobe in STARTUP and RUN, independent of collection stalls.
- State STARTUP: samples are tested but not collected. After STARTUP_SAMPLES strobes, go to RUN. The next strobe is the first collected bit.
- State RUN (collection):
  - Shift is MSB-first: sreg={sreg[W-2:0],bit}, and bitcnt increments.
  - When bitcnt reaches TRNG_WIDTH and the buffer is empty, sreg moves to the buffer on the following cycle and bitcnt clears.
  - If the buffer is full, sreg holds and subsequent samples are dropped from collection, but they are still health-tested.
  - A bit is never delivered twice.
- Delivery:
  - When trng_req=1, the buffer is full, and the state is RUN, the block registers trng_valid=1 with trng_word=buffer for exactly one cycle, then the buffer empties.
  - Latency: one cycle after trng_req is sampled high with a full buffer.
  - trng_word holds its last value afterwards.
  - trng_valid is never asserted on two consecutive cycles.
  - A request with an empty buffer waits; it is not dropped.
  - trng_req falling before valid arrives cancels the request silently.
- State FAIL:
  - Entered from STARTUP or RUN on a trip.
  - health_fail=1 from the next cycle; the buffer and sreg are cleared to 0.
  - trng_valid is never asserted again until reset.
- Simultaneous events:
  - A trip in the same cycle as a pending delivery wins: no valid pulse.
  - Buffer refill and delivery in the same cycle: delivery of the old buffer happens first, and the refill lands the next cycle.
- Reset mid-request: everything returns to reset values. Any in-progress word is lost.

Optional Feature:
TRNG_VON_NEUMANN_EN
- Defined: collection (RUN only) applies a Von Neumann debiaser to successive non-overlapping sample pairs.
  - 01 yields 0; 10 yields 1; 00 and 11 yield nothing.
  - The pair phase resets on entering RUN.
  - Health tests still see every raw sample.
- Undefined: each raw sample is collected directly.

Test Plan:
1. SAMPLE_DIV=1, STARTUP_SAMPLES=16, W=8, raw_bit alternating starting 0, trng_req held high → first trng_valid carries trng_word=0x55; health_fail stays 0 for 10000 cycles.
2. raw_bit constant 1 from reset, SAMPLE_DIV=4, RCT_CUTOFF=32 → health_fail rises the cycle after the 32nd strobe (cycle 129 after reset release); trng_valid never pulses.
3. APT_WINDOW=16, APT_CUTOFF=12, RCT_CUTOFF=32, raw pattern 1110 repeated → 12th '1' of the window trips the APT; health_fail=1 and stays 1.
4. Buffer full, trng_req pulsed high for 1 cycle → exactly one trng_valid one cycle later; a second request is served only after the next word is assembled, and it contains no reused bits.
5. Assert resetn low mid-collection with trng_req high → trng_valid=0, trng_word=0, health_fail=0 immediately (asynchronously); STARTUP restarts.
6. With TRNG_VON_NEUMANN_EN, raw pairs 01,10,00,11 repeated → collected bits 0,1,0,1…; first word 0x55.

Source files
------------

// File: rtl/trng_health_collector.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | trng_health_collector                                                  |
// | Samples a raw entropy bit at a divided rate, runs RCT/APT health tests |
// | and packs samples into words for the pwhash TRNG port.                 |
// | Optional: TRNG_VON_NEUMANN_EN enables a Von Neumann debiaser in RUN.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module trng_health_collector #(
  parameter int TRNG_WIDTH      = 8,
  parameter int SAMPLE_DIV      = 4,
  parameter int STARTUP_SAMPLES = 1024,
  parameter int RCT_CUTOFF      = 32,
  parameter int APT_WINDOW      = 512,
  parameter int APT_CUTOFF      = 410
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  raw_bit,
  input  logic                  trng_req,
  output logic [TRNG_WIDTH-1:0] trng_word,
  output logic                  trng_valid,
  output logic                  health_fail
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SU_W  = $clog2(STARTUP_SAMPLES + 1);
  localparam int RCT_W = $clog2(RCT_CUTOFF + 1);
  localparam int WIN_W = $clog2(APT_WINDOW + 1);
  localparam int APT_W = $clog2(APT_CUTOFF + 1);
  localparam int BIT_W = $clog2(TRNG_WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [SU_W-1:0]  SU_LAST  = SU_W'(STARTUP_SAMPLES - 1);
  localparam logic [RCT_W-1:0] RCT_C    = RCT_W'(RCT_CUTOFF);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(APT_WINDOW - 1);
  localparam logic [APT_W-1:0] APT_C    = APT_W'(APT_CUTOFF);
  localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(TRNG_WIDTH);

  localparam logic [1:0] ST_STARTUP = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;

  logic [1:0]            state;
  logic [DIV_W-1:0]      div;
  logic [SU_W-1:0]       su_cnt;
  logic [RCT_W-1:0]      run, run_next;
  logic                  last_bit;
  logic [WIN_W-1:0]      win;
  logic                  apt_ref;
  logic [APT_W-1:0]      apt_cnt, apt_next;
  logic [TRNG_WIDTH-1:0] sreg, buffer;
  logic [BIT_W-1:0]      bitcnt;
  logic                  buf_full;

  logic strobe, testing, trip, move, deliver;
  logic col_valid, col_bit;

  assign strobe  = (div == DIV_LAST);
  assign testing = strobe && (state != ST_FAIL);

  always_comb begin
    run_next = RCT_W'(1);
    if (run != '0 && raw_bit == last_bit)
      run_next = (run == RCT_C) ? run : run + 1'b1;
    apt_next = APT_W'(1);
    if (win != '0)
      apt_next = (raw_bit == apt_ref && apt_cnt != APT_C) ? apt_cnt + 1'b1 : apt_cnt;
  end

  assign trip    = testing && (run_next == RCT_C || apt_next == APT_C);
  // Refill needs a registered-empty buffer, so a delivery always precedes it.
  assign move    = (state == ST_RUN) && (bitcnt == BIT_FULL) && !buf_full;
  assign deliver = trng_req && buf_full && (state == ST_RUN) && !trip && !trng_valid;

`ifdef TRNG_VON_NEUMANN_EN
  logic vn_ph, vn_first;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vn_ph    <= 1'b0;
      vn_first <= 1'b0;
    end else if (state != ST_RUN) begin
      vn_ph <= 1'b0;
    end else if (strobe) begin
      vn_ph <= ~vn_ph;
      if (!vn_ph) vn_first <= raw_bit;
    end
  end

  // 01 -> 0 and 10 -> 1: the emitted bit is the first of the pair.
  assign col_valid = strobe && (state == ST_RUN) && vn_ph && (vn_first != raw_bit);
  assign col_bit   = vn_first;
`else
  assign col_valid = strobe && (state == ST_RUN);
  assign col_bit   = raw_bit;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) div <= '0;
    else         div <= strobe ? '0 : div + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_STARTUP;
      su_cnt      <= '0;
      run         <= '0;
      last_bit    <= 1'b0;
      win         <= '0;
      apt_ref     <= 1'b0;
      apt_cnt     <= '0;
      health_fail <= 1'b0;
    end else begin
      if (testing) begin
        run      <= run_next;
        last_bit <= raw_bit;
        apt_cnt  <= apt_next;
        if (win == '0) apt_ref <= raw_bit;
        win <= (win == WIN_LAST) ? '0 : win + 1'b1;
      end
      if (trip) begin
        state       <= ST_FAIL;
        health_fail <= 1'b1;
      end else if (strobe && state == ST_STARTUP) begin
        if (su_cnt == SU_LAST) state <= ST_RUN;
        else                   su_cnt <= su_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sreg       <= '0;
      bitcnt     <= '0;
      buffer     <= '0;
      buf_full   <= 1'b0;
      trng_word  <= '0;
      trng_valid <= 1'b0;
    end else begin
      trng_valid <= deliver;
      if (trip || state == ST_FAIL) begin
        sreg     <= '0;
        bitcnt   <= '0;
        buffer   <= '0;
        buf_full <= 1'b0;
      end else begin
        if (deliver) begin
          trng_word <= buffer;
          buf_full  <= 1'b0;
        end
        if (move) begin
          buffer   <= sreg;
          buf_full <= 1'b1;
        end
        // A sample arriving on the refill cycle starts the next word.
        if (col_valid && move) begin
          sreg   <= {sreg[TRNG_WIDTH-2:0], col_bit};
          bitcnt <= BIT_W'(1);
        end else if (col_valid && bitcnt != BIT_FULL) begin
          sreg   <= {sreg[TRNG_WIDTH-2:0], col_bit};
          bitcnt <= bitcnt + 1'b1;
        end else if (move) begin
          bitcnt <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trng_health_collector.sv
`default_nettype none
// Directed bench for trng_health_collector; expectations adapt to TRNG_VON_NEUMANN_EN.
module tb_trng_health_collector;

`ifdef TRNG_VON_NEUMANN_EN
  localparam int         FIRST_EDGE = 34;
  localparam logic [7:0] FIRST_WORD = 8'h00;
  localparam int         MIN_VALID  = 600;
  localparam int         VN_EDGE    = 46;
  localparam logic [7:0] VN_WORD    = 8'h55;
`else
  localparam int         FIRST_EDGE = 26;
  localparam logic [7:0] FIRST_WORD = 8'h55;
  localparam int         MIN_VALID  = 1200;
  localparam int         VN_EDGE    = 26;
  localparam logic [7:0] VN_WORD    = 8'h63;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_rstn, a_raw, a_req, a_valid, a_fail;
  logic [7:0] a_word;
  logic       r_rstn, r_raw, r_req, r_valid, r_fail;
  logic [7:0] r_word;
  logic       p_rstn, p_raw, p_req, p_valid, p_fail, q_valid, q_fail;
  logic [7:0] p_word, q_word;
  int         a_k, a_mode, p_k;

  trng_health_collector #(.TRNG_WIDTH(8), .SAMPLE_DIV(1), .STARTUP_SAMPLES(16)) dut_a (
    .clk(clk), .resetn(a_rstn), .raw_bit(a_raw), .trng_req(a_req),
    .trng_word(a_word), .trng_valid(a_valid), .health_fail(a_fail));

  trng_health_collector dut_r (
    .clk(clk), .resetn(r_rstn), .raw_bit(r_raw), .trng_req(r_req),
    .trng_word(r_word), .trng_valid(r_valid), .health_fail(r_fail));

  trng_health_collector #(.SAMPLE_DIV(1), .APT_WINDOW(16), .APT_CUTOFF(12)) dut_p (
    .clk(clk), .resetn(p_rstn), .raw_bit(p_raw), .trng_req(p_req),
    .trng_word(p_word), .trng_valid(p_valid), .health_fail(p_fail));

  trng_health_collector #(.SAMPLE_DIV(1), .APT_WINDOW(16), .APT_CUTOFF(13)) dut_q (
    .clk(clk), .resetn(p_rstn), .raw_bit(p_raw), .trng_req(p_req),
    .trng_word(q_word), .trng_valid(q_valid), .health_fail(q_fail));

  function automatic logic a_pat(input int mode, input int k);
    logic [7:0] tbl;
    tbl = 8'b1100_0110;
    case (mode)
      0:       return k[0];
      1:       return (k % 3) != 2;
      2:       return tbl[k % 8];
      default: return (k < 40) ? k[0] : 1'b1;
    endcase
  endfunction

  task automatic a_step();
    @(posedge clk); #1;
    a_k++;
    a_raw = a_pat(a_mode, a_k);
  endtask

  task automatic a_restart(input int mode);
    a_rstn = 1'b0;
    @(posedge clk); #1;
    a_mode = mode;
    a_k    = 0;
    a_raw  = a_pat(mode, 0);
    a_rstn = 1'b1;
  endtask

  task automatic p_step();
    @(posedge clk); #1;
    p_k++;
    p_raw = (p_k % 4) != 3;
  endtask

  task automatic test_reset();
    a_rstn = 0; r_rstn = 0; p_rstn = 0;
    a_raw = 0; r_raw = 0; p_raw = 0;
    a_req = 1; r_req = 1; p_req = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", a_valid); end
    checks++; if (a_word !== 8'h00) begin errors++; $display("FAIL reset_word got %h expected 00", a_word); end
    checks++; if (a_fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %b expected 0", a_fail); end
    checks++; if (r_fail !== 1'b0 || p_fail !== 1'b0) begin errors++; $display("FAIL reset_fail_others got %b%b expected 00", r_fail, p_fail); end
    a_req = 0; r_req = 0; p_req = 0;
  endtask

  task automatic test_first_word();
    int n_valid, bad_words;
    logic prev_valid, fail_seen, dbl;
    n_valid = 0; bad_words = 0; fail_seen = 0; dbl = 0;
    a_req = 1;
    a_restart(0);
    for (int n = 1; n <= FIRST_EDGE; n++) begin
      a_step();
      checks++;
      if (a_valid !== (n == FIRST_EDGE)) begin
        errors++; $display("FAIL first_valid edge %0d got %b expected %b", n, a_valid, n == FIRST_EDGE);
      end
    end
    checks++; if (a_word !== FIRST_WORD) begin errors++; $display("FAIL first_word got %h expected %h", a_word, FIRST_WORD); end
    prev_valid = a_valid;
    for (int n = 0; n < 10000; n++) begin
      a_step();
      if (a_fail) fail_seen = 1;
      if (a_valid && prev_valid) dbl = 1;
      if (a_valid) begin
        n_valid++;
        if (a_word !== FIRST_WORD) bad_words++;
      end
      prev_valid = a_valid;
    end
    checks++; if (fail_seen !== 1'b0) begin errors++; $display("FAIL long_run_health got 1 expected 0"); end
    checks++; if (dbl !== 1'b0) begin errors++; $display("FAIL valid_back_to_back got 1 expected 0"); end
    checks++; if (bad_words != 0) begin errors++; $display("FAIL steady_words got %0d bad expected 0", bad_words); end
    checks++; if (n_valid < MIN_VALID) begin errors++; $display("FAIL valid_count got %0d expected >= %0d", n_valid, MIN_VALID); end
    a_req = 0;
  endtask

  task automatic test_rct();
    logic valid_seen, dropped;
    valid_seen = 0; dropped = 0;
    r_req = 1; r_raw = 1;
    @(posedge clk); #1;
    r_rstn = 1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (r_valid) valid_seen = 1;
      if (n == 127) begin
        checks++; if (r_fail !== 1'b0) begin errors++; $display("FAIL rct_early got %b expected 0", r_fail); end
      end
      if (n == 128) begin
        checks++; if (r_fail !== 1'b1) begin errors++; $display("FAIL rct_trip got %b expected 1", r_fail); end
      end
      if (n > 128 && r_fail !== 1'b1) dropped = 1;
    end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL rct_sticky got drop expected held"); end
    checks++; if (valid_seen !== 1'b0) begin errors++; $display("FAIL rct_no_valid got pulse expected none"); end
    r_req = 0;
  endtask

  task automatic test_apt();
    logic dropped, q_seen, v_seen;
    dropped = 0; q_seen = 0; v_seen = 0;
    p_req = 1;
    @(posedge clk); #1;
    p_k = 0; p_raw = 1'b1; p_rstn = 1;
    for (int n = 1; n <= 200; n++) begin
      p_step();
      if (q_fail) q_seen = 1;
      if (p_valid || q_valid) v_seen = 1;
      if (n == 14) begin
        checks++; if (p_fail !== 1'b0) begin errors++; $display("FAIL apt_early got %b expected 0", p_fail); end
      end
      if (n == 15) begin
        checks++; if (p_fail !== 1'b1) begin errors++; $display("FAIL apt_trip got %b expected 1", p_fail); end
      end
      if (n > 15 && p_fail !== 1'b1) dropped = 1;
    end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL apt_sticky got drop expected held"); end
    checks++; if (q_seen !== 1'b0) begin errors++; $display("FAIL apt_window_restart got trip expected none"); end
    checks++; if (v_seen !== 1'b0 || q_word !== 8'h00) begin errors++; $display("FAIL apt_no_valid got valid=%b word=%h expected 0/00", v_seen, q_word); end
    p_req = 0;
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    logic [7:0] exp_w;
    a_req = 0;
    a_restart(1);
    for (int n = 1; n <= 51; n++) begin
      a_step();
      exp_v = (n == 41 || n == 44 || n == 51);
      exp_w = (n == 41) ? 8'hB6 : (n == 44) ? 8'hDB : 8'h6D;
      checks++;
      if (a_valid !== exp_v) begin errors++; $display("FAIL b2b_valid edge %0d got %b expected %b", n, a_valid, exp_v); end
      if (exp_v) begin
        checks++;
        if (a_word !== exp_w) begin errors++; $display("FAIL b2b_word edge %0d got %h expected %h", n, a_word, exp_w); end
      end
      if (n == 40) a_req = 1;
      if (n == 41) a_req = 0;
      if (n == 43) a_req = 1;
    end
  endtask

  task automatic test_reset_mid();
    a_req = 1;
    #2;
    a_rstn = 0;
    #1;
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b expected 0", a_valid); end
    checks++; if (a_word !== 8'h00) begin errors++; $display("FAIL async_word got %h expected 00", a_word); end
    checks++; if (a_fail !== 1'b0) begin errors++; $display("FAIL async_fail got %b expected 0", a_fail); end
    a_restart(0);
    for (int n = 1; n <= FIRST_EDGE; n++) begin
      a_step();
      checks++;
      if (a_valid !== (n == FIRST_EDGE)) begin
        errors++; $display("FAIL restart_valid edge %0d got %b expected %b", n, a_valid, n == FIRST_EDGE);
      end
    end
    checks++; if (a_word !== FIRST_WORD) begin errors++; $display("FAIL restart_word got %h expected %h", a_word, FIRST_WORD); end
    a_req = 0;
  endtask

  task automatic test_vn_pairs();
    a_req = 1;
    a_restart(2);
    for (int n = 1; n <= VN_EDGE; n++) begin
      a_step();
      checks++;
      if (a_valid !== (n == VN_EDGE)) begin
        errors++; $display("FAIL pairs_valid edge %0d got %b expected %b", n, a_valid, n == VN_EDGE);
      end
    end
    checks++; if (a_word !== VN_WORD) begin errors++; $display("FAIL pairs_word got %h expected %h", a_word, VN_WORD); end
    a_req = 0;
  endtask

  task automatic test_fail_in_run();
    logic v_seen;
    v_seen = 0;
    a_req = 0;
    a_restart(3);
    for (int n = 1; n <= 100; n++) begin
      a_step();
      if (a_valid) v_seen = 1;
      if (n == 70) begin
        checks++; if (a_fail !== 1'b0) begin errors++; $display("FAIL run_trip_early got %b expected 0", a_fail); end
        a_req = 1;
      end
      if (n == 71) begin
        checks++; if (a_fail !== 1'b1) begin errors++; $display("FAIL run_trip got %b expected 1", a_fail); end
      end
    end
    checks++; if (v_seen !== 1'b0) begin errors++; $display("FAIL trip_beats_delivery got pulse expected none"); end
    checks++; if (a_word !== 8'h00 || a_fail !== 1'b1) begin errors++; $display("FAIL fail_state got word=%h fail=%b expected 00/1", a_word, a_fail); end
    a_req = 0;
  endtask

  initial begin
    a_mode = 0; a_k = 0; p_k = 0;
    test_reset();
    test_first_word();
    test_rct();
    test_apt();
`ifndef TRNG_VON_NEUMANN_EN
    test_back_to_back();
`endif
    test_reset_mid();
    test_vn_pairs();
    test_fail_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
